// File: rtl/decode_queue.sv
// decode_queue
//   Instruction decode stage with a queue of decoded entries for the execute
//   stage. Raw MIPS words enter through a valid/ready handshake. Each word is
//   classified (R/I/J), its immediate is extended and its jump target is
//   computed before it is stored, so the head entry presents fully decoded
//   fields straight from storage.
//
//   Optional feature: define DECODE_ILLEGAL_EN to flag unsupported opcodes and
//   R-type functs on 'illegal'. Without it, 'illegal' is tied to 0 and no
//   legality logic or storage exists.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   flush           drop every queued entry and any same-cycle push/pop
//   in_valid/ready  input handshake for instr + in_pc
//   out_valid/ready output handshake for the head entry
//   opcode..addr    raw instruction fields of the head entry
//   itype           0=R, 1=I, 2=J
//   imm_ext         extended immediate (zero/lui/sign)
//   jump_target     {pc_plus4[XLEN-1:28], addr, 2'b00}
//   out_pc          PC of the head entry
//   illegal         head entry is an unsupported encoding
//   count           current occupancy 0..DEPTH
module decode_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [5:0]       opcode,
  output logic [5:0]       funct,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [4:0]       shamt,
  output logic [15:0]      imm,
  output logic [25:0]      addr,
  output logic [1:0]       itype,
  output logic [XLEN-1:0]  imm_ext,
  output logic [XLEN-1:0]  jump_target,
  output logic [XLEN-1:0]  out_pc,
  output logic             illegal,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  function automatic logic [1:0] f_itype(input logic [5:0] op);
    logic [1:0] t;
    case (op)
      6'h00:        t = 2'd0;
      6'h02, 6'h03: t = 2'd2;
      default:      t = 2'd1;
    endcase
    return t;
  endfunction

  function automatic logic [XLEN-1:0] f_imm_ext(input logic [5:0] op, input logic [15:0] im);
    logic [XLEN-1:0] e;
    case (op)
      6'h0C, 6'h0D, 6'h0E: e = XLEN'(im);
      6'h0F:               e = XLEN'({im, 16'h0000});
      default:             e = {{(XLEN-16){im[15]}}, im};
    endcase
    return e;
  endfunction

`ifdef DECODE_ILLEGAL_EN
  function automatic logic f_illegal(input logic [5:0] op, input logic [5:0] fn);
    logic bad;
    case (op)
      6'h00: begin
        case (fn)
          6'h00, 6'h02, 6'h03, 6'h08, 6'h20, 6'h21, 6'h22, 6'h23,
          6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: bad = 1'b0;
          default: bad = 1'b1;
        endcase
      end
      6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B,
      6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B: bad = 1'b0;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction
`endif

  logic [31:0]      instr_mem_r [DEPTH];
  logic [XLEN-1:0]  pc_mem_r    [DEPTH];
  logic [XLEN-1:0]  imm_mem_r   [DEPTH];
  logic [XLEN-1:0]  jt_mem_r    [DEPTH];
  logic [1:0]       itype_mem_r [DEPTH];
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [CNT_W-1:0] count_r;

  logic                 push_s;
  logic                 pop_s;
  logic [XLEN-29:0]     pc_hi_s;
  logic [XLEN-1:0]      jt_s;
  logic [31:0]          head_instr_s;

  assign in_ready  = !rst && (count_r < FULL_CNT);
  assign out_valid = !rst && (count_r != {CNT_W{1'b0}});
  assign count     = rst ? {CNT_W{1'b0}} : count_r;
  assign push_s    = in_valid && in_ready && !flush;
  assign pop_s     = out_valid && out_ready && !flush;

  // Upper bits of in_pc + 4: bits [27:0] only carry into bit 28 when
  // in_pc[27:2] is all ones, so the low sum bits are never built.
  assign pc_hi_s = in_pc[XLEN-1:28] + (XLEN-28)'(&in_pc[27:2]);
  assign jt_s    = {pc_hi_s, instr[25:0], 2'b00};

  // Pointer and occupancy state; reset and flush clear it and beat any push/pop.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else begin
      if (push_s) tail_r <= tail_r + PTR_W'(1);
      if (pop_s)  head_r <= head_r + PTR_W'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Decoded entry storage, written at the tail on every push.
  always_ff @(posedge clk) begin
    if (push_s) begin
      instr_mem_r[tail_r] <= instr;
      pc_mem_r[tail_r]    <= in_pc;
      imm_mem_r[tail_r]   <= f_imm_ext(instr[31:26], instr[15:0]);
      jt_mem_r[tail_r]    <= jt_s;
      itype_mem_r[tail_r] <= f_itype(instr[31:26]);
    end
  end

  assign head_instr_s = instr_mem_r[head_r];

  // Head fields, forced to zero whenever no valid entry is presented.
  always_comb begin
    opcode      = 6'd0;
    funct       = 6'd0;
    rs          = 5'd0;
    rt          = 5'd0;
    rd          = 5'd0;
    shamt       = 5'd0;
    imm         = 16'd0;
    addr        = 26'd0;
    itype       = 2'd0;
    imm_ext     = {XLEN{1'b0}};
    jump_target = {XLEN{1'b0}};
    out_pc      = {XLEN{1'b0}};
    if (out_valid) begin
      opcode      = head_instr_s[31:26];
      funct       = head_instr_s[5:0];
      rs          = head_instr_s[25:21];
      rt          = head_instr_s[20:16];
      rd          = head_instr_s[15:11];
      shamt       = head_instr_s[10:6];
      imm         = head_instr_s[15:0];
      addr        = head_instr_s[25:0];
      itype       = itype_mem_r[head_r];
      imm_ext     = imm_mem_r[head_r];
      jump_target = jt_mem_r[head_r];
      out_pc      = pc_mem_r[head_r];
    end else begin
      opcode = 6'd0;
    end
  end

`ifdef DECODE_ILLEGAL_EN
  logic ill_mem_r [DEPTH];

  // Legality flag stored alongside each entry.
  always_ff @(posedge clk) begin
    if (push_s) begin
      ill_mem_r[tail_r] <= f_illegal(instr[31:26], instr[5:0]);
    end
  end

  assign illegal = out_valid && ill_mem_r[head_r];
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_decode_queue.sv
module tb_decode_queue;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] addr;
    logic [1:0]  itype;
    logic [31:0] imm_ext;
    logic [31:0] jump_target;
    logic [31:0] out_pc;
    logic        illegal;
  } head_t;

  logic clk = 1'b0;
  logic rst, flush, in_valid, out_ready;
  logic [31:0] instr, in_pc;
  logic in_ready, out_valid, illegal;
  logic [5:0] opcode, funct;
  logic [4:0] rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [25:0] addr;
  logic [1:0] itype;
  logic [31:0] imm_ext, jump_target, out_pc;
  logic [CNT_W-1:0] count;

  int n_cmp = 0;
  int n_err = 0;
  int model_cnt = 0;
  head_t sb[$];

  always #5 clk = ~clk;

  decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .opcode(opcode), .funct(funct), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
    .imm(imm), .addr(addr), .itype(itype), .imm_ext(imm_ext),
    .jump_target(jump_target), .out_pc(out_pc), .illegal(illegal), .count(count)
  );

  // Reference decode of one instruction word, written from the field definitions.
  function automatic head_t m_decode(input logic [31:0] w, input logic [31:0] pc);
    head_t h;
    logic [31:0] p4;
    h.opcode = w[31:26]; h.rs = w[25:21]; h.rt = w[20:16]; h.rd = w[15:11];
    h.shamt = w[10:6]; h.funct = w[5:0]; h.imm = w[15:0]; h.addr = w[25:0];
    if (h.opcode == 6'h00) h.itype = 2'd0;
    else if (h.opcode == 6'h02 || h.opcode == 6'h03) h.itype = 2'd2;
    else h.itype = 2'd1;
    if (h.opcode inside {6'h0C, 6'h0D, 6'h0E}) h.imm_ext = {16'h0000, h.imm};
    else if (h.opcode == 6'h0F) h.imm_ext = {h.imm, 16'h0000};
    else h.imm_ext = {{16{h.imm[15]}}, h.imm};
    p4 = pc + 32'd4;
    h.jump_target = {p4[31:28], h.addr, 2'b00};
    h.out_pc = pc;
`ifdef DECODE_ILLEGAL_EN
    if (h.opcode == 6'h00)
      h.illegal = !(h.funct inside {6'h00, 6'h02, 6'h03, 6'h08, 6'h20, 6'h21, 6'h22,
                                    6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B});
    else
      h.illegal = !(h.opcode inside {6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A,
                                     6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B});
`else
    h.illegal = 1'b0;
`endif
    return h;
  endfunction

  // One clock: drive inputs, check the current head/handshake against the
  // scoreboard, update the model, advance past the edge.
  task automatic cycle(input logic v, input logic [31:0] w, input logic [31:0] pc,
                       input logic ordy, input logic fl);
    head_t act, exp_h;
    logic exp_rdy, do_push, do_pop;
    in_valid = v; instr = w; in_pc = pc; out_ready = ordy; flush = fl;
    #1;
    exp_rdy = (model_cnt < DEPTH);
    act = '{opcode, rs, rt, rd, shamt, funct, imm, addr, itype, imm_ext,
            jump_target, out_pc, illegal};
    exp_h = (model_cnt != 0) ? sb[0] : '0;
    n_cmp++;
    if (in_ready !== exp_rdy) begin
      n_err++; $display("FAIL in_ready: got %0b want %0b", in_ready, exp_rdy);
    end
    n_cmp++;
    if (count !== CNT_W'(model_cnt)) begin
      n_err++; $display("FAIL count: got %0d want %0d", count, model_cnt);
    end
    n_cmp++;
    if (out_valid !== (model_cnt != 0)) begin
      n_err++; $display("FAIL out_valid: got %0b want %0b", out_valid, model_cnt != 0);
    end
    n_cmp++;
    if (act !== exp_h) begin
      n_err++; $display("FAIL head: got %h want %h", act, exp_h);
    end
    do_push = v && exp_rdy && !fl;
    do_pop  = (model_cnt != 0) && ordy && !fl;
    if (fl) begin
      sb.delete();
      model_cnt = 0;
    end else begin
      if (do_pop) begin void'(sb.pop_front()); model_cnt--; end
      if (do_push) begin sb.push_back(m_decode(w, pc)); model_cnt++; end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instr = 32'h0; in_pc = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({in_ready, out_valid, count, imm_ext, out_pc, illegal} !== '0) begin
      n_err++; $display("FAIL reset_outs: rdy=%0b vld=%0b cnt=%0d", in_ready, out_valid, count);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL ready_after_reset: got %0b want 1", in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    cycle(1'b1, 32'h2128FFFC, 32'h00400000, 1'b0, 1'b0);
    n_cmp++;
    if ({out_valid, itype, rs, rt, imm_ext} !== {1'b1, 2'd1, 5'd9, 5'd8, 32'hFFFFFFFC}) begin
      n_err++;
      $display("FAIL addi: got vld=%0b it=%0d rs=%0d rt=%0d ext=%h want 1 1 9 8 fffffffc",
               out_valid, itype, rs, rt, imm_ext);
    end
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    cycle(1'b1, 32'h3508FFFF, 32'h00400004, 1'b1, 1'b0);
    n_cmp++;
    if (imm_ext !== 32'h0000FFFF) begin
      n_err++; $display("FAIL ori_ext: got %h want 0000ffff", imm_ext);
    end
    cycle(1'b1, 32'h3C081234, 32'h00400008, 1'b1, 1'b0);
    n_cmp++;
    if (imm_ext !== 32'h12340000) begin
      n_err++; $display("FAIL lui_ext: got %h want 12340000", imm_ext);
    end
    cycle(1'b1, 32'h012A4020, 32'h0040000C, 1'b1, 1'b0);
    n_cmp++;
    if ({itype, rd, funct, count} !== {2'd0, 5'd8, 6'h20, 3'd1}) begin
      n_err++; $display("FAIL add: got it=%0d rd=%0d fn=%h cnt=%0d want 0 8 20 1",
                        itype, rd, funct, count);
    end
    cycle(1'b1, 32'h08100004, 32'hFFFFFFFC, 1'b1, 1'b0);
    n_cmp++;
    if ({itype, jump_target} !== {2'd2, 32'h00400010}) begin
      n_err++; $display("FAIL jump: got it=%0d jt=%h want 2 00400010", itype, jump_target);
    end
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_fill();
    for (int i = 0; i < 5; i++)
      cycle(1'b1, 32'h20000000 + 32'(i * 17), 32'h1000 + 32'(4 * i), 1'b0, 1'b0);
    n_cmp++;
    if ({count, in_ready} !== {3'd4, 1'b0}) begin
      n_err++; $display("FAIL full: got cnt=%0d rdy=%0b want 4 0", count, in_ready);
    end
    cycle(1'b1, 32'h24420001, 32'h2000, 1'b1, 1'b0);
    n_cmp++;
    if (count !== 3'd3) begin
      n_err++; $display("FAIL full_pop_only: got %0d want 3", count);
    end
    for (int i = 0; i < 4; i++)
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 32'h8C000000 + 32'(i), 32'h3000 + 32'(4 * i), 1'b0, 1'b0);
    cycle(1'b1, 32'hAC000000, 32'h4000, 1'b1, 1'b1);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    n_cmp++;
    if ({count, out_valid, out_pc} !== '0) begin
      n_err++; $display("FAIL flush: got cnt=%0d vld=%0b pc=%h want 0", count, out_valid, out_pc);
    end
    cycle(1'b1, 32'h10220005, 32'h5000, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_midstream();
    cycle(1'b1, 32'h8D090004, 32'h6000, 1'b0, 1'b0);
    cycle(1'b1, 32'hAD090008, 32'h6004, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({in_ready, out_valid, count, out_pc} !== '0) begin
      n_err++; $display("FAIL rst_mid: got rdy=%0b vld=%0b cnt=%0d", in_ready, out_valid, count);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    model_cnt = 0;
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle(1'b1, 32'h00851021, 32'h7000, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_illegal();
    logic exp_ill;
`ifdef DECODE_ILLEGAL_EN
    exp_ill = 1'b1;
`else
    exp_ill = 1'b0;
`endif
    cycle(1'b1, 32'hFC000000, 32'h8000, 1'b1, 1'b0);
    n_cmp++;
    if (illegal !== exp_ill) begin
      n_err++; $display("FAIL ill_opcode: got %0b want %0b", illegal, exp_ill);
    end
    cycle(1'b1, 32'h0000003F, 32'h8004, 1'b1, 1'b0);
    n_cmp++;
    if (illegal !== exp_ill) begin
      n_err++; $display("FAIL ill_funct: got %0b want %0b", illegal, exp_ill);
    end
    cycle(1'b1, 32'h012A4020, 32'h8008, 1'b1, 1'b0);
    n_cmp++;
    if (illegal !== 1'b0) begin
      n_err++; $display("FAIL ill_add: got %0b want 0", illegal);
    end
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fill();
    test_flush();
    test_reset_midstream();
    test_illegal();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/decode_queue.md
# decode_queue

Parametrised instruction decode stage with a decoded-instruction queue. Accepts raw 32-bit MIPS instruction words plus their PC through a valid/ready handshake. Splits each word into R/I/J fields, classifies the format, and extends the immediate. Computes the jump target and buffers up to DEPTH decoded entries for the execute stage, with a single-cycle pipeline flush.

## Interface
- XLEN, 32: datapath/PC width for imm_ext, pc and jump_target; must be >= 32.
- DEPTH, 4: queue entries; power of two, >= 2.
- CNT_W, $clog2(DEPTH)+1: width of occupancy count.

- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  discard all queued entries and any same-cycle input.
- in_valid  input  1  instr/in_pc valid.
- in_ready  output  1  queue can accept this cycle.
- instr  input  32  raw instruction word.
- in_pc  input  XLEN  address of instr.
- out_valid  output  1  head entry valid.
- out_ready  input  1  consumer takes head this cycle.
- opcode, funct  output  6 each  instr[31:26], instr[5:0].
- rs, rt, rd, shamt  output  5 each  instr[25:21], [20:16], [15:11], [10:6].
- imm  output  16  instr[15:0].
- addr  output  26  instr[25:0].
- itype  output  2  0=R, 1=I, 2=J; 3 is never produced.
- imm_ext  output  XLEN  extended immediate.
- jump_target  output  XLEN  {pc_plus4[XLEN-1:28], addr, 2'b00}.
- out_pc  output  XLEN  PC of the head entry.
- illegal  output  1  head is an unsupported encoding; see Configuration.
- count  output  CNT_W  current occupancy, 0..DEPTH.

## Operation
- Push: occurs when in_valid && in_ready && !flush. The word is decoded combinationally and written into the tail entry.
- Pop: occurs when out_valid && out_ready && !flush. The head advances.
- Push and pop in the same cycle are both performed; count is unchanged.
- in_ready = !rst && (count < DEPTH).
  - A full queue does not accept input, even when a pop occurs in the same cycle.
- out_valid = (count != 0).
- All head fields (opcode..illegal, out_pc) read 0 while out_valid = 0.
- itype:
  - opcode 0x00 -> R.
  - 0x02 and 0x03 -> J.
  - Every other opcode -> I.
- imm_ext:
  - opcode 0x0C, 0x0D, 0x0E (andi/ori/xori): zero-extended.
  - 0x0F (lui): {imm, 16'b0}, zero-extended to XLEN.
  - All others: sign-extended from imm[15].
- jump_target uses pc_plus4 = in_pc + 4, computed modulo 2^XLEN; wrap-around at the top of the address space is allowed. It is computed for every entry regardless of itype.
- Head/tail pointers are log2(DEPTH) bits and wrap naturally.
- Flush: clears count and pointers to 0 at the next edge. Flush wins over a push or pop in the same cycle; neither takes effect.
- Reset: same effect as flush. Every output is 0 during and after reset until the first push, with one exception: in_ready, which is 0 while rst = 1 and 1 from the first cycle with rst = 0.
- Reset or flush mid-stream loses all queued entries; no partial entry survives.

## Timing
- Latency: a word pushed at edge N into an empty queue presents out_valid = 1 with its fields after edge N. There is no combinational input-to-output bypass.
- Throughput: one push and one pop per cycle when 0 < count < DEPTH.
- count is registered and updated at the same edge as the pointers.
- in_ready depends only on registered count and rst; there is no combinational path from out_ready.
- Fields are stable while out_valid = 1 && out_ready = 0.

## Configuration
- DECODE_ILLEGAL_EN defined: illegal = 1 for the head entry in either of these cases.
  - opcode not in {00,02,03,04,05,08,09,0A,0B,0C,0D,0E,0F,23,2B}.
  - opcode = 00 and funct not in {00,02,03,08,20,21,22,23,24,25,26,27,2A,2B}.
  - The entry is still queued and delivered normally; the consumer decides its handling.
- Not defined: illegal is tied to 0; no legality logic or storage is synthesised.

## Test plan
- Reset then single push: instr 0x2128FFFC (addi), pc 0x00400000 -> one cycle later out_valid = 1, itype = 1, rs = 9, rt = 8, imm_ext = 0xFFFFFFFC. With out_ready = 1, out_valid falls the next cycle.
- Extension modes: ori 0x3508FFFF -> imm_ext = 0x0000FFFF. lui 0x3C081234 -> imm_ext = 0x12340000. R-type 0x012A4020 (add) -> itype = 0, rd = 8, funct = 0x20.
- Jump: instr 0x0810_0004 at pc 0xFFFFFFFC -> pc_plus4 wraps to 0, jump_target = 0x00400010, itype = 2.
- Fill/backpressure, DEPTH = 4, out_ready = 0: after 4 pushes count = 4 and in_ready = 0. A simultaneous in_valid + out_ready at full pops only, giving count 3. Draining returns the entries in push order.
- Flush: queue holds 3, then flush = 1 with in_valid = 1 and out_ready = 1 -> next cycle count = 0, out_valid = 0, all fields 0, no entry retained.
- DECODE_ILLEGAL_EN: opcode 0x3F -> illegal = 1. R-type funct 0x3F -> illegal = 1. Valid add -> illegal = 0. Without the macro, illegal stays 0 for all three.
